// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store initiator for a word-wide data memory.
// Sub-word stores are done as read-modify-write on the word port.
module load_store_unit #(
  parameter int ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

  // Shifting by 32 yields zero, so ADDR_BITS=32 disables the range check.
  localparam logic [31:0] HI_MASK = 32'hFFFF_FFFF << ADDR_BITS;

  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic        acc_err;
  logic        bad_f3;
  logic        misal;
  logic [7:0]  lane;
  logic [15:0] half;
  logic [31:0] ld_val;
  logic [31:0] merged;

  always_comb begin
    bad_f3 = 1'b0;
    misal  = 1'b0;
    unique case (1'b1)
      req_store: bad_f3 = (req_funct3[2] || req_funct3[1:0] == 2'b11);
      default:   bad_f3 = (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    endcase
    unique case (1'b1)
      req_funct3[1:0] == 2'b01: misal = req_addr[0];
      req_funct3[1:0] == 2'b10: misal = (req_addr[1:0] != 2'b00);
      default:                  misal = 1'b0;
    endcase
    acc_err = bad_f3 || misal || ((req_addr & HI_MASK) != 32'h0);
  end

  always_comb begin
    lane   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half   = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    ld_val = mem_rdata;
    unique case (f3_q)
      3'b000:  ld_val = {{24{lane[7]}}, lane};
      3'b100:  ld_val = {24'h0, lane};
      3'b001:  ld_val = {{16{half[15]}}, half};
      3'b101:  ld_val = {16'h0, half};
      default: ld_val = mem_rdata;
    endcase
    merged = mem_rdata;
    if (f3_q[0]) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wbuf_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wbuf_q[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wbuf_d  = req_wdata;
          data_d  = 32'h0;
          err_d   = acc_err;
          if (acc_err) begin
            state_d = S_RESP;
          end else if (req_store && req_funct3 == 3'b010) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        if (store_q) begin
          wbuf_d  = merged;
          state_d = S_WR;
        end else begin
          data_d  = ld_val;
          state_d = S_RESP;
        end
      end
      S_WR: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wbuf_q  <= 32'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign mem_read  = (state_q == S_RD);
  assign mem_write = (state_q == S_WR);
  assign mem_addr  = addr_q & ~HI_MASK & 32'hFFFF_FFFC;
  assign mem_wdata = wbuf_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit
// with a word memory model (negedge write, registered read).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_BITS(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic [31:0] rdata_q;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int cyc = 0;
  int rd_cyc = 0;
  int wr_cyc = 0;
  int addr_bad = 0;

  assign mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (mem_read) rdata_q <= mem[mem_addr[11:2]];
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      wr_cyc <= cyc;
    end
    if (mem_read) begin
      rd_cnt <= rd_cnt + 1;
      rd_cyc <= cyc;
    end
    if ((mem_read || mem_write) && mem_addr[1:0] != 2'b00)
      addr_bad <= addr_bad + 1;
  end

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic push(input logic e, input logic [31:0] d);
    exp_t x;
    x.err  = e;
    x.data = d;
    sb_q.push_back(x);
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat);
    int lat;
    exp_t x;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, x.err});
      chk({tag, "_data"}, rsp_data, x.data);
    end
  endtask

  task automatic do_req(input string tag, input logic st,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic e,
                        input logic [31:0] d, input int lat,
                        input int nrd, input int nwr);
    int r0, w0, n;
    drive(st, f3, a, wd);
    push(e, d);
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    r0 = rd_cnt;
    w0 = wr_cnt;
    tick();
    req_valid = 1'b0;
    wait_rsp(tag, lat);
    chk({tag, "_nrd"}, rd_cnt - r0, nrd);
    chk({tag, "_nwr"}, wr_cnt - w0, nwr);
    if (nrd == 1 && nwr == 1)
      chk({tag, "_rd_wr_gap"}, wr_cyc - rd_cyc, 2);
    tick();
    chk({tag, "_ready_after"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int r0, w0;
    logic [31:0] held;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_funct3 = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    do_req("sw100", 1, 3'b010, 32'h100, 32'h8899AABB, 0, 32'h0, 2, 0, 1);
    do_req("lw100", 0, 3'b010, 32'h100, 0, 0, 32'h8899AABB, 3, 1, 0);
    do_req("lb103", 0, 3'b000, 32'h103, 0, 0, 32'hFFFFFF88, 3, 1, 0);
    do_req("lbu103", 0, 3'b100, 32'h103, 0, 0, 32'h00000088, 3, 1, 0);
    do_req("lh102", 0, 3'b001, 32'h102, 0, 0, 32'hFFFF8899, 3, 1, 0);
    do_req("lhu100", 0, 3'b101, 32'h100, 0, 0, 32'h0000AABB, 3, 1, 0);

    do_req("sb101", 1, 3'b000, 32'h101, 32'h12345677, 0, 0, 4, 1, 1);
    do_req("lw_sb", 0, 3'b010, 32'h100, 0, 0, 32'h889977BB, 3, 1, 0);
    do_req("sh102", 1, 3'b001, 32'h102, 32'h0000CAFE, 0, 0, 4, 1, 1);
    do_req("lw_sh", 0, 3'b010, 32'h100, 0, 0, 32'hCAFE77BB, 3, 1, 0);

    do_req("e_lw102", 0, 3'b010, 32'h102, 0, 1, 32'h0, 1, 0, 0);
    do_req("e_sh101", 1, 3'b001, 32'h101, 32'h55, 1, 32'h0, 1, 0, 0);
    do_req("e_range", 0, 3'b000, 32'h00010000, 0, 1, 32'h0, 1, 0, 0);
    do_req("e_f3_011", 0, 3'b011, 32'h100, 0, 1, 32'h0, 1, 0, 0);
    do_req("e_sf3_100", 1, 3'b100, 32'h100, 0, 1, 32'h0, 1, 0, 0);

    // backpressure
    rsp_ready = 1'b0;
    drive(0, 3'b010, 32'h100, 0);
    push(0, 32'hCAFE77BB);
    tick();
    req_valid = 1'b0;
    wait_rsp("bp_lw", 3);
    held = rsp_data;
    r0 = rd_cnt;
    w0 = wr_cnt;
    drive(1, 3'b010, 32'h104, 32'h11111111);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, held);
      chk("bp_ready", {31'b0, req_ready}, 32'd0);
    end
    chk("bp_no_strobe", (rd_cnt - r0) + (wr_cnt - w0), 0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
    chk("bp_release_valid", {31'b0, rsp_valid}, 32'd0);

    // reset while in RD of a sub-word store
    w0 = wr_cnt;
    drive(1, 3'b000, 32'h100, 32'h000000AA);
    tick();
    req_valid = 1'b0;
    chk("mr_in_rd", {31'b0, mem_read}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_ready", {31'b0, req_ready}, 32'd1);
    chk("mr_outs", {29'b0, rsp_valid, mem_read, mem_write}, 32'd0);
    chk("mr_data", rsp_data | mem_addr | mem_wdata, 32'h0);
    tick();
    tick();
    chk("mr_no_write", wr_cnt - w0, 0);
    do_req("mr_lw", 0, 3'b010, 32'h100, 0, 0, 32'hCAFE77BB, 3, 1, 0);

    // back-to-back with req_valid held
    drive(1, 3'b010, 32'h200, 32'hDEADBEEF);
    push(0, 32'h0);
    push(0, 32'hDEADBEEF);
    tick();
    drive(0, 3'b010, 32'h200, 0);
    wait_rsp("b2b_sw", 2);
    tick();
    chk("b2b_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("b2b_accepted", {30'b0, req_ready, mem_read}, 32'd1);
    wait_rsp("b2b_lw", 3);
    tick();
    chk("sb_drained", sb_q.size(), 0);
    chk("addr_aligned", addr_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the word-wide data-memory interface: accepts RV32I load/store requests from the execute stage and drives mem_read/mem_write/mem_addr/mem_wdata.
- Performs byte-lane selection and sign/zero extension for loads.
- Performs read-modify-write for SB/SH, since the memory port is word-only (write sampled on negedge, read registered on posedge).
- Returns one response per request over a valid/ready handshake.

Parameters:
- ADDR_BITS, 16, implemented byte-address width (range 3..32); any request with a nonzero bit in req_addr[31:ADDR_BITS] is out of range. At 32 there is no range check.

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; equals (state==IDLE)
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned, out of range, or illegal funct3
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  32  word-aligned byte address: {zeros, req_addr[ADDR_BITS-1:2], 2'b00}
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  memory read data; valid the cycle after a mem_read cycle

Behaviour:
- Reset (posedge with rst=1):
  - state=IDLE.
  - rsp_valid, rsp_err, mem_read, mem_write = 0.
  - rsp_data, mem_addr, mem_wdata = 0.
  - All latched request fields cleared.
- Output timing: mem_* and rsp_* are decoded from registered state/fields only, with no combinational path from req_* or rsp_ready. This keeps them stable across the negedge write sample.
- Acceptance: on posedge with req_valid & req_ready, latch store, funct3, addr and wdata.
- Error check at accept: error if any of:
  - illegal funct3 (load: 011/110/111; store: anything other than 000/001/010);
  - out of range;
  - misaligned (H/HU/SH with addr[0]=1, or W with addr[1:0]!=0).
  - On error: go to RESP with rsp_err=1, rsp_data=0. No memory strobe is ever asserted.
- States:
  - IDLE: accept request. Next state: error -> RESP; load or SB/SH -> RD; SW -> WR.
  - RD: mem_read=1 for exactly one cycle. -> CAP.
  - CAP: mem_rdata valid.
    - Load: lane k = mem_rdata[8k+7:8k], k=addr[1:0]. LB sign-extends lane, LBU zero-extends. LH/LHU use half addr[1] (bits 16*addr[1]+15 down to 16*addr[1]), sign- or zero-extended. LW takes the word. Register the result into rsp_data, then -> RESP.
    - SB/SH: merge wdata[7:0] into byte lane addr[1:0] (SB) or wdata[15:0] into half addr[1] (SH); other lanes keep mem_rdata. Store the merged word in the write buffer, then -> WR.
  - WR: mem_write=1 for exactly one cycle. mem_wdata is the merged word (SB/SH) or latched wdata (SW). -> RESP.
  - RESP: rsp_valid=1; rsp_data/rsp_err held stable. On rsp_ready -> IDLE. Otherwise hold.
- Latency, in posedges from the accept edge to rsp_valid high:
  - error: 1
  - SW: 2
  - load: 3
  - SB/SH: 4
- Throughput: at most one request in flight. req_ready stays low from the accept edge through the response handshake edge. With rsp_ready tied high, the next accept can occur on the edge after the one that leaves RESP.
- Backpressure: rsp_ready low holds RESP indefinitely with all outputs constant. req_valid is ignored while req_ready is low.
- Reset mid-operation:
  - rst takes effect at the posedge. A WR cycle in progress when rst is sampled still performs its negedge write.
  - After the reset edge, no strobe is asserted and any pending response is discarded.
  - Reset in RD/CAP of an SB/SH means no write ever occurs and the memory word is unchanged.
- Address: lanes are little-endian. mem_addr always has [1:0]=00 and zeros above ADDR_BITS-1.

Test Plan:
- SW 0x100 data 0x8899AABB, then loads:
  - LW 0x100 -> 0x8899AABB
  - LB 0x103 -> 0xFFFFFF88
  - LBU 0x103 -> 0x00000088
  - LH 0x102 -> 0xFFFF8899
  - LHU 0x100 -> 0x0000AABB
  - Check rsp_valid exactly 3 edges after each accept and mem_read high exactly one cycle.
- Sub-word stores on the same word:
  - SB 0x101 data 0x12345677 -> LW returns 0x889977BB.
  - Then SH 0x102 data 0x0000CAFE -> LW returns 0xCAFE77BB.
  - Each SB/SH shows mem_read, one idle cycle, then mem_write, with 4-edge latency.
- Errors, each giving rsp_err=1, rsp_data=0, mem_read/mem_write never high, 1-edge latency:
  - LW 0x102
  - SH 0x101
  - LB 0x00010000 (ADDR_BITS=16)
  - load funct3=011
- Backpressure: hold rsp_ready=0 for 5 cycles after an LW. rsp_valid stays 1, rsp_data constant, req_ready stays 0, and a concurrent req_valid is not accepted. Release: handshake, then req_ready=1 the next cycle.
- Reset mid-op: assert rst for one edge while in RD of SB 0x100. Next cycle is IDLE with all outputs 0 and no mem_write ever. A subsequent LW 0x100 returns the pre-store value.
- Back-to-back: rsp_ready tied 1, req_valid held. SW 0x200 data 0xDEADBEEF immediately followed by LW 0x200 -> LW returns 0xDEADBEEF, one response per request in order.
